// File: rtl/fos_mc_scheduler.sv
// Multi-channel first-order recursive section (y = x + s, s' = a1*y) that time-shares one
// radix-4 Booth multiplier and one adder across NCH channels with round-robin grants.
module fos_mc_scheduler #(
  parameter int NCH = 4,
  localparam int CW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH*32-1:0] x_in,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  input  logic              cfg_we,
  input  logic [CW-1:0]     cfg_ch,
  input  logic [10:0]       cfg_a1,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [CW-1:0]     out_ch
);

  logic [31:0]   state [NCH];
  logic [10:0]   coef  [NCH];
  logic [31:0]   y_reg;
  logic [10:0]   a1_reg;
  logic [CW-1:0] ch_reg;
  logic [CW-1:0] rr;
  logic          b_vld;

  logic [NCH-1:0] elig;
  logic           gnt_found;
  logic [CW-1:0]  gnt_ch;
  logic [CW-1:0]  idx;
  logic [31:0]    gnt_x;
  logic           stall;
  logic           grant;
  logic           take;
  logic [31:0]    prod;
  logic [12:0]    a_ext;
  logic [2:0]     grp;
  logic [31:0]    pp;

  assign out_valid = b_vld;
  assign out_data  = y_reg;
  assign out_ch    = ch_reg;
  assign stall     = b_vld && !out_ready;
  assign take      = b_vld && out_ready;
  assign grant     = gnt_found && !stall && !flush;

  // A channel whose previous result is still in stage B must wait until its state is written back.
  always_comb begin
    for (int c = 0; c < NCH; c++)
      elig[c] = in_valid[c] && !(b_vld && ch_reg == CW'(c));
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = '0;
    idx       = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = CW'((int'(rr) + i) % NCH);
      if (!gnt_found && elig[idx]) begin
        gnt_found = 1'b1;
        gnt_ch    = idx;
      end
    end
  end

  always_comb begin
    gnt_x    = '0;
    in_ready = '0;
    for (int c = 0; c < NCH; c++) begin
      if (gnt_ch == CW'(c)) gnt_x = x_in[32*c +: 32];
      in_ready[c] = grant && (gnt_ch == CW'(c));
    end
  end

  // Radix-4 Booth: a1 is signed, recoded into six digits in {-2..2}; only the low 32 bits are kept.
  always_comb begin
    a_ext = {a1_reg[10], a1_reg, 1'b0};
    prod  = '0;
    grp   = '0;
    pp    = '0;
    for (int i = 0; i < 6; i++) begin
      grp = a_ext[2*i +: 3];
      case (grp)
        3'b001, 3'b010: pp = y_reg;
        3'b011:         pp = y_reg << 1;
        3'b100:         pp = ~(y_reg << 1) + 32'd1;
        3'b101, 3'b110: pp = ~y_reg + 32'd1;
        default:        pp = '0;
      endcase
      prod = prod + (pp << (2 * i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        state[c] <= '0;
        coef[c]  <= '0;
      end
      y_reg  <= '0;
      a1_reg <= '0;
      ch_reg <= '0;
      rr     <= '0;
      b_vld  <= 1'b0;
    end else begin
      if (cfg_we) coef[cfg_ch] <= cfg_a1;
      if (flush) begin
        for (int c = 0; c < NCH; c++) state[c] <= '0;
        b_vld <= 1'b0;
        rr    <= '0;
      end else begin
        if (take) state[ch_reg] <= prod;
        if (grant) begin
          y_reg  <= gnt_x + state[gnt_ch];
          a1_reg <= coef[gnt_ch];
          ch_reg <= gnt_ch;
          rr     <= (gnt_ch == CW'(NCH - 1)) ? '0 : gnt_ch + 1'b1;
          b_vld  <= 1'b1;
        end else if (take) begin
          b_vld <= 1'b0;
        end
      end
    end
  end

endmodule
